// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, wait-counter width,
// response codes and the parity helper used when MEM_PARITY_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 4;

  localparam logic RSP_OK       = 1'b0;
  localparam logic RSP_ADDR_ERR = 1'b1;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/dm_storage_array.sv
// Word storage for the responder: synchronous write, registered read.
// With MEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module dm_storage_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_bad
);

`ifdef MEM_PARITY_EN
  logic [DATA_W:0] mem [2**ADDR_W];
  logic [DATA_W:0] rd_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= {even_parity(32'(wdata)), wdata};
    end
    if (re) begin
      rd_reg <= mem[addr];
    end
  end

  assign rdata   = rd_reg[DATA_W-1:0];
  // A good word has even total parity, so any odd result flags corruption.
  assign par_bad = ^rd_reg;
`else
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rd_reg <= mem[addr];
    end
  end

  assign rdata   = rd_reg;
  assign par_bad = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, WAIT_CYCLES wait-states,
// response held until taken. Optional read parity checking via MEM_PARITY_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              par_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

  state_t                  state_reg;
  logic [WAIT_CNT_W-1:0]   cnt_reg;
  logic                    ready_reg;
  logic                    we_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic                    code_reg;

  logic                    addr_bad;
  logic                    access;
  logic                    mem_we;
  logic                    mem_re;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    mem_par_bad;

  assign addr_bad = (req_addr >> ADDR_W) != 16'd0;

  // The final wait cycle is the storage access edge; the registered read then
  // lines up with the first response cycle.
  assign access = (state_reg == ST_WAIT) && (cnt_reg == '0) && !rst;
  assign mem_we = access && we_reg && (code_reg == RSP_OK);
  assign mem_re = access && !we_reg && (code_reg == RSP_OK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      code_reg  <= RSP_OK;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid && ready_reg) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr[ADDR_W-1:0];
            wdata_reg <= req_wdata;
            code_reg  <= addr_bad ? RSP_ADDR_ERR : RSP_OK;
            cnt_reg   <= WAIT_INIT;
            ready_reg <= 1'b0;
            state_reg <= ST_WAIT;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  dm_storage_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (addr_reg),
    .wdata   (wdata_reg),
    .rdata   (mem_rdata),
    .par_bad (mem_par_bad)
  );

  // Response fields come only from registers that stay frozen while in RESP.
  assign req_ready = ready_reg;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_valid && (code_reg == RSP_ADDR_ERR);
  assign rsp_rdata = (rsp_valid && !we_reg && (code_reg == RSP_OK)) ? mem_rdata : '0;
  assign par_err   = rsp_valid && !we_reg && (code_reg == RSP_OK) && mem_par_bad;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus hand-written corner
// sequences; a second instance runs with zero wait-states. Parity case under MEM_PARITY_EN.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, par_err;
  logic [15:0] rsp_rdata;

  logic        r0_valid = 1'b0, r0_we = 1'b0, r0_rsp_ready = 1'b0;
  logic [15:0] r0_addr = '0, r0_wdata = '0;
  logic        r0_ready, r0_rsp_valid, r0_rsp_err, r0_par_err;
  logic [15:0] r0_rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_q[$];
  int hs_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .par_err(par_err)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_ready(r0_ready),
    .req_we(r0_we), .req_addr(r0_addr), .req_wdata(r0_wdata),
    .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready), .rsp_rdata(r0_rdata),
    .rsp_err(r0_rsp_err), .par_err(r0_par_err)
  );

  // Handshake log for the zero-wait instance, stamped with the edge index.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (r0_valid && r0_ready) acc_q.push_back(cyc);
    if (r0_rsp_valid && r0_rsp_ready) hs_q.push_back(cyc);
  end

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic e, output logic pe, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; e = rsp_err; pe = par_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("[TB] %s addr=%04h wdata=%04h -> rdata=%04h err=%0b par=%0b lat=%0d",
             we ? "WR" : "RD", a, d, rd, e, pe, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [15:0] rd;
    logic        e, pe, seen;
    int          lat;

    vecs[0]  = '{1'b1, 16'h0001, 16'hABCD, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'h0001, 16'h0000, 16'hABCD, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
    vecs[5]  = '{1'b1, 16'h0005, 16'h1111, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 16'h00FF, 16'hFFFF, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 16'h00FF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[8]  = '{1'b0, 16'h8001, 16'h0000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b0, 16'h0005, 16'h0000, 16'h1111, 1'b0};
    vecs[10] = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_par_err", par_err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", req_ready, 1);

    // Vector table: latency is 1 + WAIT_CYCLES = 3 edges after accept
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e, pe, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_par", i), pe, 0);
      check($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Stalled response: rsp_ready low for 5 cycles
    txn(1'b1, 16'h0001, 16'hABCD, rd, e, pe, lat);
    @(negedge clk);
    req_we = 1'b0; req_addr = 16'h0001; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_lat", lat, 3);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_valid", k), rsp_valid, 1);
      check($sformatf("stall%0d_rdata", k), rsp_rdata, 16'hABCD);
      check($sformatf("stall%0d_req_ready", k), req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("stall_idle_valid", rsp_valid, 0);
    check("stall_idle_ready", req_ready, 1);
    $display("[TB] RD addr=0001 stalled 5 cycles -> rdata=ABCD");

    // Reset on the access edge of a pending write drops it
    @(negedge clk);
    req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h5555; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_low", req_ready, 0);
    check("midrst_valid_low", rsp_valid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready_back", req_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_rsp", seen, 0);
    $display("[TB] WR addr=0005 wdata=5555 dropped by reset");
    txn(1'b0, 16'h0005, 16'h0000, rd, e, pe, lat);
    check("midrst_read_old", rd, 16'h1111);

    // Zero wait-states, back-to-back reads with rsp_ready held high
    acc_q.delete();
    hs_q.delete();
    @(negedge clk);
    r0_we = 1'b0; r0_addr = 16'h0003; r0_rsp_ready = 1'b1; r0_valid = 1'b1;
    repeat (10) @(negedge clk);
    r0_valid = 1'b0;
    repeat (6) @(negedge clk);
    r0_rsp_ready = 1'b0;
    check("w0_accepts", (acc_q.size() >= 3), 1);
    if (acc_q.size() >= 3 && hs_q.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        // valid rises after accept edge + 1, so the handshake lands at accept + 2
        check($sformatf("w0_rsp%0d_delay", k), hs_q[k] - acc_q[k], 2);
        $display("[TB] W0 RD addr=0003 accept@%0d handshake@%0d", acc_q[k], hs_q[k]);
      end
      check("w0_spacing01", acc_q[1] - acc_q[0], 3);
      check("w0_spacing12", acc_q[2] - acc_q[1], 3);
    end else begin
      check("w0_handshakes", (hs_q.size() >= 3), 1);
    end

`ifdef MEM_PARITY_EN
    txn(1'b1, 16'h0002, 16'h00FF, rd, e, pe, lat);
    dut.u_store.mem[2] = dut.u_store.mem[2] ^ 17'h00001;
    txn(1'b0, 16'h0002, 16'h0000, rd, e, pe, lat);
    check("parity_err", pe, 1);
    check("parity_rdata", rd, 16'h00FE);
    txn(1'b0, 16'h0001, 16'h0000, rd, e, pe, lat);
    check("parity_clean", pe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
